// File: rtl/test_cam_pkg.sv
// Shared constants, capture state encoding and address helper for the
// OV7670 capture / VGA display block.
package test_cam_pkg;

  // Captured image and frame-buffer geometry
  localparam int IMG_W    = 160;
  localparam int IMG_H    = 120;
  localparam int AW       = 15;
  localparam int DW       = 12;
  localparam int PIX_DIV  = 4;
  localparam int FB_DEPTH = IMG_W * IMG_H;

  localparam logic [AW-1:0] ADDR_MAX = AW'(FB_DEPTH - 1);

  // 640x480 @ 60 Hz VGA timing, in pixel units
  localparam int H_TOTAL      = 800;
  localparam int H_VIS        = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_TOTAL      = 525;
  localparam int V_VIS        = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_BYTE1 = 2'd1,
    CAP_BYTE2 = 2'd2
  } cap_state_t;

  // Linear frame-buffer address of captured pixel (row, col)
  function automatic logic [AW-1:0] fb_addr(input logic [9:0] row, input logic [9:0] col);
    return AW'(row) * AW'(IMG_W) + AW'(col);
  endfunction

endpackage

// File: rtl/buffer_ram_dp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module buffer_ram_dp #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [DEPTH];

  // Port A write
  // NOTE: the array has no reset so it maps onto block RAM; contents are
  // undefined until the camera writes them.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  // Port B registered read (old data on same-address collision)
  always_ff @(posedge clk) begin
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/test_cam_capture.sv
// OV7670 RGB444 capture into a 160x120 frame buffer, scanned out as the
// top-left window of a 640x480 VGA image. Single clock domain (clk).
module test_cam_capture
  import test_cam_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_PCLK,
  input  logic          CAM_HREF,
  input  logic          CAM_VSYNC,
  input  logic [7:0]    CAM_px_data,
  output logic          CAM_xclk,
  output logic          CAM_pwdn,
  output logic          CAM_reset,
  output logic          VGA_Hsync_n,
  output logic          VGA_Vsync_n,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic [DW-1:0] data_mem,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic [AW-1:0] DP_RAM_addr_out
);

  // ---------------- camera input synchroniser ----------------
  logic [1:0] pclk_sync, href_sync, vsync_sync;
  logic [7:0] px_meta, px_sync;
  logic       pclk_prev;
  logic       pclk_rise;

  // Two-flop synchronisers plus a delayed PCLK copy for edge detection
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_sync  <= '0;
      href_sync  <= '0;
      vsync_sync <= '0;
      px_meta    <= '0;
      px_sync    <= '0;
      pclk_prev  <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[0], CAM_PCLK};
      href_sync  <= {href_sync[0], CAM_HREF};
      vsync_sync <= {vsync_sync[0], CAM_VSYNC};
      px_meta    <= CAM_px_data;
      px_sync    <= px_meta;
      pclk_prev  <= pclk_sync[1];
    end
  end

  assign pclk_rise = pclk_sync[1] & ~pclk_prev;

  // ---------------- capture FSM ----------------
  cap_state_t    state_q, state_d;
  logic [3:0]    red_q, red_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          full_q, full_d;

  // Capture state and write-port registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CAP_IDLE;
      red_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      red_q     <= red_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      full_q    <= full_d;
    end
  end

  // Next-state: byte pairing, write strobe, address advance and saturation
  // NOTE: every signal gets its default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    red_d     = red_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    full_d    = full_q;

    // The address moves on the cycle after the word lands in RAM; the last
    // word of the buffer freezes it and blocks writes until the next frame.
    if (wr_en_q) begin
      if (wr_addr_q == ADDR_MAX) full_d = 1'b1;
      else                       wr_addr_d = wr_addr_q + AW'(1);
    end

    if (pclk_rise) begin
      if (vsync_sync[1]) begin
        state_d   = CAP_IDLE;
        wr_addr_d = '0;
        full_d    = 1'b0;
      end else if (!href_sync[1]) begin
        // Line gap: realign to the first byte, keep the address so
        // consecutive lines pack back to back.
        if (state_q != CAP_IDLE) state_d = CAP_BYTE1;
      end else begin
        unique case (state_q)
          // Leaving IDLE happens on the first active byte, which is byte 1
          // of the first pixel, so it is latched just like in BYTE1.
          CAP_IDLE, CAP_BYTE1: begin
            red_d   = px_sync[3:0];
            state_d = CAP_BYTE2;
          end
          CAP_BYTE2: begin
            if (!full_q) begin
              wr_data_d = {red_q, px_sync};
              wr_en_d   = 1'b1;
            end
            state_d = CAP_BYTE1;
          end
          default: state_d = CAP_IDLE;
        endcase
      end
    end
  end

  // ---------------- VGA timing ----------------
  logic [1:0] pix_cnt;
  logic       pix_en;
  logic [9:0] h_cnt, v_cnt;
  logic       xclk_q;

  assign pix_en = (pix_cnt == 2'(PIX_DIV - 1));

  // Pixel divider, camera master clock and raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      xclk_q  <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      pix_cnt <= pix_en ? 2'd0 : pix_cnt + 2'd1;
      if (pix_cnt[0]) xclk_q <= ~xclk_q;
      if (pix_en) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  logic          in_win, hs_raw, vs_raw;
  logic [AW-1:0] rd_addr_d;

  // Raster decode: capture window, sync pulses, read address
  always_comb begin
    in_win    = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS)) &&
                (h_cnt < 10'(IMG_W)) && (v_cnt < 10'(IMG_H));
    hs_raw    = !((h_cnt >= 10'(H_SYNC_START)) && (h_cnt < 10'(H_SYNC_END)));
    vs_raw    = !((v_cnt >= 10'(V_SYNC_START)) && (v_cnt < 10'(V_SYNC_END)));
    rd_addr_d = in_win ? fb_addr(v_cnt, h_cnt) : '0;
  end

  logic          hs_p1, vs_p1, win_p1;
  logic          hs_p2, vs_p2, win_p2;
  logic [AW-1:0] rd_addr_q;

  // Two-stage pipeline: stage 1 issues the RAM read, stage 2 meets its data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      win_p1    <= 1'b0;
      hs_p2     <= 1'b1;
      vs_p2     <= 1'b1;
      win_p2    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      hs_p1     <= hs_raw;
      vs_p1     <= vs_raw;
      win_p1    <= in_win;
      hs_p2     <= hs_p1;
      vs_p2     <= vs_p1;
      win_p2    <= win_p1;
    end
  end

  // ---------------- frame buffer ----------------
  buffer_ram_dp #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (FB_DEPTH)
  ) u_fb (
    .clk    (clk),
    .we_a   (wr_en_q),
    .addr_a (wr_addr_q),
    .din_a  (wr_data_q),
    .addr_b (rd_addr_q),
    .dout_b (data_mem)
  );

  // ---------------- outputs ----------------
  assign CAM_xclk        = xclk_q;
  assign CAM_pwdn        = 1'b0;
  assign CAM_reset       = 1'b1;
  assign VGA_Hsync_n     = hs_p2;
  assign VGA_Vsync_n     = vs_p2;
  assign VGA_R           = win_p2 ? data_mem[11:8] : 4'h0;
  assign VGA_G           = win_p2 ? data_mem[7:4]  : 4'h0;
  assign VGA_B           = win_p2 ? data_mem[3:0]  : 4'h0;
  assign DP_RAM_addr_in  = wr_addr_q;
  assign DP_RAM_data_in  = wr_data_q;
  assign DP_RAM_addr_out = rd_addr_q;

endmodule

// File: tb/tb_test_cam_capture.sv
// Directed bench for test_cam_capture: reset, pixel packing, VGA readback,
// sync timing, full-frame saturation and mid-line asynchronous reset.
module tb_test_cam_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        CAM_PCLK, CAM_HREF, CAM_VSYNC;
  logic [7:0]  CAM_px_data;
  logic        CAM_xclk, CAM_pwdn, CAM_reset;
  logic        VGA_Hsync_n, VGA_Vsync_n;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic [11:0] data_mem, DP_RAM_data_in;
  logic [14:0] DP_RAM_addr_in, DP_RAM_addr_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  test_cam_capture dut (
    .clk             (clk),
    .rst             (rst),
    .CAM_PCLK        (CAM_PCLK),
    .CAM_HREF        (CAM_HREF),
    .CAM_VSYNC       (CAM_VSYNC),
    .CAM_px_data     (CAM_px_data),
    .CAM_xclk        (CAM_xclk),
    .CAM_pwdn        (CAM_pwdn),
    .CAM_reset       (CAM_reset),
    .VGA_Hsync_n     (VGA_Hsync_n),
    .VGA_Vsync_n     (VGA_Vsync_n),
    .VGA_R           (VGA_R),
    .VGA_G           (VGA_G),
    .VGA_B           (VGA_B),
    .data_mem        (data_mem),
    .DP_RAM_addr_in  (DP_RAM_addr_in),
    .DP_RAM_data_in  (DP_RAM_data_in),
    .DP_RAM_addr_out (DP_RAM_addr_out)
  );

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One camera byte: PCLK low for 'half' clks with data set, then high
  task automatic cam_byte(input logic [7:0] b, input int half);
    CAM_px_data = b;
    CAM_PCLK    = 1'b0;
    tick(half);
    CAM_PCLK    = 1'b1;
    tick(half);
  endtask

  // One RGB444 pixel; the unused upper nibble of byte 1 carries junk
  task automatic cam_pixel(input logic [11:0] p, input int half);
    cam_byte({~p[11:8], p[11:8]}, half);
    cam_byte(p[7:0], half);
  endtask

  task automatic cam_idle(input int n);
    CAM_HREF = 1'b0;
    repeat (n) cam_byte(8'h00, 1);
  endtask

  task automatic vsync_pulse;
    CAM_HREF  = 1'b0;
    CAM_VSYNC = 1'b1;
    repeat (3) cam_byte(8'h00, 1);
    CAM_VSYNC = 1'b0;
    repeat (2) cam_byte(8'h00, 1);
  endtask

  task automatic pulse_reset;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int   toggles;
    logic prev;
    rst = 1'b0;
    tick(20);
    n_checks++;
    if (DP_RAM_addr_in !== 15'd0) begin
      n_errors++; $display("FAIL reset_addr_in: got %0d want 0", DP_RAM_addr_in);
    end
    n_checks++;
    if (DP_RAM_addr_out !== 15'd0) begin
      n_errors++; $display("FAIL reset_addr_out: got %0d want 0", DP_RAM_addr_out);
    end
    n_checks++;
    if (DP_RAM_data_in !== 12'h000) begin
      n_errors++; $display("FAIL reset_data_in: got %h want 000", DP_RAM_data_in);
    end
    n_checks++;
    if ({VGA_Hsync_n, VGA_Vsync_n} !== 2'b11) begin
      n_errors++; $display("FAIL reset_syncs: got %b want 11", {VGA_Hsync_n, VGA_Vsync_n});
    end
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
      n_errors++; $display("FAIL reset_rgb: got %h want 000", {VGA_R, VGA_G, VGA_B});
    end
    n_checks++;
    if ({CAM_pwdn, CAM_reset, CAM_xclk} !== 3'b010) begin
      n_errors++; $display("FAIL reset_cam_ctrl: got %b want 010", {CAM_pwdn, CAM_reset, CAM_xclk});
    end
    rst = 1'b1;
    tick(1);
    prev    = CAM_xclk;
    toggles = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (CAM_xclk !== prev) toggles++;
      prev = CAM_xclk;
    end
    n_checks++;
    if (toggles != 8) begin
      n_errors++; $display("FAIL xclk_toggles: got %0d want 8 in 16 clk", toggles);
    end
  endtask

  task automatic test_pixel_pack;
    vsync_pulse();
    CAM_HREF = 1'b1;
    cam_byte(8'h0F, 2);
    cam_byte(8'hF0, 2);
    tick(6);
    n_checks++;
    if (DP_RAM_data_in !== 12'hFF0) begin
      n_errors++; $display("FAIL pack1_data: got %h want ff0", DP_RAM_data_in);
    end
    n_checks++;
    if (DP_RAM_addr_in !== 15'd1) begin
      n_errors++; $display("FAIL pack1_addr: got %0d want 1", DP_RAM_addr_in);
    end
    cam_byte(8'hF0, 2);
    cam_byte(8'h0F, 2);
    tick(6);
    n_checks++;
    if (DP_RAM_data_in !== 12'h00F) begin
      n_errors++; $display("FAIL pack2_data: got %h want 00f", DP_RAM_data_in);
    end
    n_checks++;
    if (DP_RAM_addr_in !== 15'd2) begin
      n_errors++; $display("FAIL pack2_addr: got %0d want 2", DP_RAM_addr_in);
    end
    // A lone byte followed by an HREF gap must be discarded
    cam_byte(8'h05, 1);
    cam_idle(2);
    CAM_HREF = 1'b1;
    cam_byte(8'h0A, 1);
    cam_byte(8'hBC, 1);
    cam_idle(3);
    n_checks++;
    if (DP_RAM_data_in !== 12'hABC || DP_RAM_addr_in !== 15'd3) begin
      n_errors++;
      $display("FAIL phase_realign: got data %h addr %0d want abc addr 3", DP_RAM_data_in, DP_RAM_addr_in);
    end
  endtask

  task automatic test_readback;
    bit found = 0;
    pulse_reset();
    vsync_pulse();
    CAM_HREF = 1'b1;
    for (int i = 0; i < 161; i++) cam_pixel(12'h123, 1);
    cam_pixel(12'hABC, 1);
    cam_idle(3);
    for (int i = 0; i < 6000; i++) begin
      if (DP_RAM_addr_out === 15'd161) begin
        found = 1;
        break;
      end
      tick(1);
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL readback_wait: addr_out never reached 161 within 6000 clk");
      return;
    end
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h123) begin
      n_errors++; $display("FAIL readback_h0: got %h want 123", {VGA_R, VGA_G, VGA_B});
    end
    tick(1);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'hABC) begin
      n_errors++; $display("FAIL readback_rgb: got %h want abc", {VGA_R, VGA_G, VGA_B});
    end
    n_checks++;
    if (data_mem !== 12'hABC) begin
      n_errors++; $display("FAIL readback_data_mem: got %h want abc", data_mem);
    end
    tick(158 * 4 - 1);
    n_checks++;
    if (DP_RAM_addr_out !== 15'd319) begin
      n_errors++; $display("FAIL window_last_col: got %0d want 319", DP_RAM_addr_out);
    end
    tick(4);
    n_checks++;
    if (DP_RAM_addr_out !== 15'd0) begin
      n_errors++; $display("FAIL window_exit_addr: got %0d want 0", DP_RAM_addr_out);
    end
    tick(1);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
      n_errors++; $display("FAIL window_exit_rgb: got %h want 000", {VGA_R, VGA_G, VGA_B});
    end
    tick(39 * 4);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h000 || DP_RAM_addr_out !== 15'd0) begin
      n_errors++;
      $display("FAIL h200_blank: got rgb %h addr %0d want 000 addr 0", {VGA_R, VGA_G, VGA_B}, DP_RAM_addr_out);
    end
  endtask

  task automatic test_vga_timing;
    int   low_cnt = 1;
    int   period  = 0;
    bit   found   = 0;
    bit   vs_bad  = 0;
    logic prev_hs;
    prev_hs = VGA_Hsync_n;
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      if (VGA_Hsync_n === 1'b0 && prev_hs === 1'b1) begin
        found = 1;
        break;
      end
      prev_hs = VGA_Hsync_n;
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL hsync_wait: no Hsync_n fall within 4000 clk");
      return;
    end
    prev_hs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      period++;
      if (VGA_Vsync_n !== 1'b1) vs_bad = 1;
      if (VGA_Hsync_n === 1'b0 && prev_hs === 1'b1) break;
      if (VGA_Hsync_n === 1'b0) low_cnt++;
      prev_hs = VGA_Hsync_n;
    end
    n_checks++;
    if (low_cnt != 384) begin
      n_errors++; $display("FAIL hsync_width: got %0d clk want 384", low_cnt);
    end
    n_checks++;
    if (period != 3200) begin
      n_errors++; $display("FAIL line_period: got %0d clk want 3200", period);
    end
    n_checks++;
    if (vs_bad) begin
      n_errors++; $display("FAIL vsync_early: got Vsync_n low want high on lines below 490");
    end
  endtask

  task automatic test_full_frame;
    pulse_reset();
    vsync_pulse();
    cam_idle(32);
    for (int line = 0; line < 120; line++) begin
      CAM_HREF = 1'b1;
      for (int px = 0; px < 160; px++) cam_pixel(12'(line * 160 + px), 1);
      cam_idle(4);
      if (line == 0) begin
        n_checks++;
        if (DP_RAM_addr_in !== 15'd160) begin
          n_errors++; $display("FAIL line0_addr: got %0d want 160", DP_RAM_addr_in);
        end
      end
    end
    n_checks++;
    if (DP_RAM_addr_in !== 15'd19199) begin
      n_errors++; $display("FAIL frame_end_addr: got %0d want 19199", DP_RAM_addr_in);
    end
    n_checks++;
    if (DP_RAM_data_in !== 12'hAFF) begin
      n_errors++; $display("FAIL frame_end_data: got %h want aff", DP_RAM_data_in);
    end
    CAM_HREF = 1'b1;
    repeat (4) cam_pixel(12'h333, 1);
    cam_idle(4);
    n_checks++;
    if (DP_RAM_addr_in !== 15'd19199 || DP_RAM_data_in !== 12'hAFF) begin
      n_errors++;
      $display("FAIL saturate: got addr %0d data %h want 19199 aff", DP_RAM_addr_in, DP_RAM_data_in);
    end
    vsync_pulse();
    n_checks++;
    if (DP_RAM_addr_in !== 15'd0) begin
      n_errors++; $display("FAIL vsync_clear: got %0d want 0", DP_RAM_addr_in);
    end
  endtask

  task automatic test_async_reset;
    vsync_pulse();
    CAM_HREF = 1'b1;
    cam_pixel(12'h777, 1);
    cam_byte(8'h01, 1);
    tick(4);
    n_checks++;
    if (DP_RAM_addr_in !== 15'd1 || DP_RAM_data_in !== 12'h777) begin
      n_errors++;
      $display("FAIL midline_pre: got addr %0d data %h want 1 777", DP_RAM_addr_in, DP_RAM_data_in);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (DP_RAM_addr_in !== 15'd0 || DP_RAM_data_in !== 12'h000) begin
      n_errors++;
      $display("FAIL async_clear: got addr %0d data %h want 0 000", DP_RAM_addr_in, DP_RAM_data_in);
    end
    CAM_HREF = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    vsync_pulse();
    CAM_HREF = 1'b1;
    cam_pixel(12'hCDE, 1);
    cam_idle(3);
    n_checks++;
    if (DP_RAM_addr_in !== 15'd1 || DP_RAM_data_in !== 12'hCDE) begin
      n_errors++;
      $display("FAIL restart: got addr %0d data %h want 1 cde", DP_RAM_addr_in, DP_RAM_data_in);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst         = 1'b0;
    CAM_PCLK    = 1'b0;
    CAM_HREF    = 1'b0;
    CAM_VSYNC   = 1'b1;
    CAM_px_data = 8'h00;
    tick(1);
    test_reset();
    test_pixel_pack();
    test_readback();
    test_vga_timing();
    test_full_frame();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $fatal(1);
  end

endmodule

// File: doc/test_cam_capture.md
Name: test_cam_capture

Overview:
- Top-level capture-and-display block for an OV7670-style camera.
- Samples the camera's RGB444 byte stream (2 bytes/pixel, 160x120 frame) into an on-chip dual-port frame buffer of 19200 x 12 bit.
- Scans that buffer out to a 640x480 VGA port from the same system clock.
- Exposes buffer write/read addresses and data for debug.

Parameters:
- IMG_W, 160, captured pixels per line
- IMG_H, 120, captured lines per frame
- AW, 15, frame-buffer address width
- DW, 12, pixel width (RGB444)
- PIX_DIV, 4, clk cycles per VGA pixel / CAM_xclk period

Ports:
- clk  in  1  system clock, 100 MHz; only clock domain
- rst  in  1  asynchronous active-low reset
- CAM_PCLK  in  1  camera pixel clock, sampled as data
- CAM_HREF  in  1  line-valid, high during active bytes
- CAM_VSYNC  in  1  frame sync, high between frames
- CAM_px_data  in  8  camera byte
- CAM_xclk  out  1  camera master clock, clk/4 square wave
- CAM_pwdn  out  1  constant 0
- CAM_reset  out  1  constant 1 (camera not held in reset)
- VGA_Hsync_n  out  1  horizontal sync, active low
- VGA_Vsync_n  out  1  vertical sync, active low
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- data_mem  out  12  frame-buffer read data
- DP_RAM_addr_in  out  15  write address
- DP_RAM_data_in  out  12  write data
- DP_RAM_addr_out  out  15  read address

Behaviour:
- Reset (rst=0, async), all registers clear:
  - addresses 0, write data 0
  - byte phase 0, VGA counters 0
  - Hsync_n/Vsync_n = 1, RGB = 0, CAM_xclk = 0
- Camera input sync:
  - CAM_PCLK, HREF, VSYNC and px_data pass through a 2-flop synchroniser.
  - pclk_rise = sync_pclk & ~prev_pclk; one clk pulse per PCLK rising edge.
  - All capture logic advances only on pclk_rise.
- Capture FSM, states IDLE, BYTE1, BYTE2:
  - VSYNC=1 (any state) -> IDLE; write address := 0; byte phase := 0.
  - IDLE -> BYTE1 on pclk_rise with VSYNC=0 and HREF=1.
  - Byte 1 (phase 0) with HREF=1: latch px_data[3:0] as R; -> BYTE2.
  - Byte 2 (phase 1) with HREF=1:
    - DP_RAM_data_in := {R, px_data[7:4] G, px_data[3:0] B}.
    - Single-cycle write strobe.
    - Write address increments after the write.
    - -> BYTE1.
  - HREF=0 on pclk_rise -> byte phase := BYTE1; address is kept, so lines pack contiguously.
- Write address bounds:
  - Writes land at addresses 0..19199.
  - At 19199 the address saturates and further writes are suppressed until VSYNC.
  - A frame shorter than 19200 pixels leaves the remaining words unchanged.
- Frame buffer (dual-port RAM):
  - Synchronous write on port A.
  - Synchronous read on port B, 1-clk latency; data_mem = port-B output.
  - Contents uninitialised; simulation may preload zero.
- VGA timing:
  - Pixel enable every 4th clk (25 MHz).
  - H: 800 total, visible 0..639, Hsync_n low for h in 656..751.
  - V: 525 total, visible 0..479, Vsync_n low for v in 490..491.
- Display mapping:
  - Window h<160 and v<120: DP_RAM_addr_out = v*160 + h.
  - Outside the window: addr_out = 0 and RGB = 0.
- Output pipeline:
  - Sync and window-valid flags are delayed to match the 1-clk RAM latency.
  - All outputs are registered.
  - Inside the window, RGB = {data_mem[11:8], [7:4], [3:0]}.
- Simultaneous write and read of the same address: the read returns the old data.
- CAM_xclk toggles every 2 clk.

Decomposition:
- Package test_cam_pkg holds:
  - IMG_W, IMG_H, AW, DW
  - VGA timing constants (800/640/656/752, 525/480/490/492)
  - capture state enum
- One natural sub-module: buffer_ram_dp (parameterised AW/DW, 1 write port, 1 registered read port).
- Capture FSM and VGA scan stay in the top.

Test Plan:
- Reset: hold rst=0 for 20 clk -> addr_in=0, addr_out=0, Hsync_n=Vsync_n=1, RGB=0, CAM_pwdn=0, CAM_reset=1.
- Pixel pack:
  - Stimulus: VSYNC=0, HREF=1, PCLK period 4 clk, bytes 0x0F then 0xF0.
  - Required: DP_RAM_data_in=0xFF0 written at addr 0; addr_in=1.
  - Next pair 0xF0, 0x0F -> 0x00F at addr 1.
- Full frame:
  - Stimulus: 120 lines x 320 bytes, 4-PCLK HREF gaps, 4 blank lines.
  - Required: final addr_in=19199, no write beyond it; VSYNC pulse returns addr_in to 0.
- VGA timing:
  - Hsync_n low exactly 96 pixels (384 clk) per 800-pixel line.
  - Vsync_n low 2 lines per 525.
  - Frame period 1,680,000 clk.
- Readback:
  - Preload addr 161 = 0xABC.
  - Required: at h=1, v=1, RGB = A,B,C one clk after addr_out=161.
  - At h=200, RGB = 0.
- Async reset mid-line (rst low during HREF): FSM returns to IDLE immediately; after release, capture waits for VSYNC then restarts at addr 0.
